// File: rtl/fpadd_ctrl.sv
// fpadd_ctrl: sequencer and two-port round-robin arbiter for a shared,
// non-pipelined FP adder datapath (mask -> align -> alu -> normal -> pack).
// One operand pair is in flight at a time; the packed result is captured
// and returned together with the ID of the requester that issued it.
// Optional feature macro: FPADD_CTRL_ZERO_BYPASS_EN (zero-operand bypass).
module fpadd_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    output logic [4:0]        dp_stage_en,
    input  logic [DATA_W-1:0] dp_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result
);

    typedef enum logic [2:0] {
        IDLE,
        S_MASK,
        S_ALIGN,
        S_ALU,
        S_NORM,
        S_PACK,
        CAPTURE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;          // requester favoured when both are valid
    logic [DATA_W-1:0] dp_a_q, dp_a_d;
    logic [DATA_W-1:0] dp_b_q, dp_b_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;

    logic              gnt0, gnt1;
    logic [4:0]        stage_en;
    logic              done_valid;
    logic [DATA_W-1:0] sel_a, sel_b;

`ifdef FPADD_CTRL_ZERO_BYPASS_EN
    logic              a_zero, b_zero;
`endif

    // State and datapath-facing registers; reset aborts any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= RR_INIT;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            dp_a_q        <= dp_a_d;
            dp_b_q        <= dp_b_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
        end
    end

    // Arbitration, stage sequencing and next-state logic
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        dp_a_d        = dp_a_q;
        dp_b_d        = dp_b_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        stage_en      = '0;
        done_valid    = 1'b0;
        sel_a         = gnt1 ? req1_a : req0_a;
        sel_b         = gnt1 ? req1_b : req0_b;
`ifdef FPADD_CTRL_ZERO_BYPASS_EN
        a_zero        = 1'b0;
        b_zero        = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                gnt0  = req0_valid & (~req1_valid | ~rr_q);
                gnt1  = req1_valid & (~req0_valid |  rr_q);
                sel_a = gnt1 ? req1_a : req0_a;
                sel_b = gnt1 ? req1_b : req0_b;
                if (gnt0 | gnt1) begin
                    dp_a_d    = sel_a;
                    dp_b_d    = sel_b;
                    resp_id_d = gnt1;
                    rr_d      = ~gnt1;
                    state_d   = S_MASK;
`ifdef FPADD_CTRL_ZERO_BYPASS_EN
                    a_zero = ~|sel_a[DATA_W-2:0];
                    b_zero = ~|sel_b[DATA_W-2:0];
                    if (a_zero & b_zero) begin
                        resp_result_d = {sel_a[DATA_W-1] & sel_b[DATA_W-1], {(DATA_W-1){1'b0}}};
                        state_d       = DONE;
                    end else if (a_zero) begin
                        resp_result_d = sel_b;
                        state_d       = DONE;
                    end else if (b_zero) begin
                        resp_result_d = sel_a;
                        state_d       = DONE;
                    end
`endif
                end
            end
            S_MASK: begin
                stage_en = 5'b00001;
                state_d  = S_ALIGN;
            end
            S_ALIGN: begin
                stage_en = 5'b00010;
                state_d  = S_ALU;
            end
            S_ALU: begin
                stage_en = 5'b00100;
                state_d  = S_NORM;
            end
            S_NORM: begin
                stage_en = 5'b01000;
                state_d  = S_PACK;
            end
            S_PACK: begin
                stage_en = 5'b10000;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                resp_result_d = dp_result;
                state_d       = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is asserted
    assign req0_ready  = gnt0 & ~reset;
    assign req1_ready  = gnt1 & ~reset;
    assign dp_stage_en = reset ? 5'b00000 : stage_en;
    assign resp_valid  = done_valid & ~reset;
    assign dp_a        = dp_a_q;
    assign dp_b        = dp_b_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;

endmodule
